edsac_clk_gen: RTL and testbench
================================

EDSAC_CLK_GEN -- requirements
Module: edsac_clk_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 8: width of the half-period divisor.
REQ-002 SHALL have parameter DIV_DEFAULT, default 100: reset half-period in clk cycles; gives 500 kHz from 100 MHz.
REQ-003 SHALL have parameter STEP_W, default 8: width of the step counter.
REQ-004 SHALL have port: clk  in  1  single system clock, all logic on posedge.
REQ-005 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port: run  in  1  level; free-run request.
REQ-007 SHALL have port: step_req  in  1  one-cycle pulse; start a burst of step_n periods.
REQ-008 SHALL have port: step_n  in  STEP_W  number of periods per burst, sampled with step_req.
REQ-009 SHALL have port: div_load  in  1  one-cycle pulse; load div_val.
REQ-010 SHALL have port: div_val  in  DIV_W  new half-period.
REQ-011 SHALL have port: clk_out  out  1  divided clock, registered.
REQ-012 SHALL have port: tick  out  1  one-cycle pulse, registered, asserted in the same cycle clk_out rises.
REQ-013 SHALL have port: busy  out  1  high in RUN or STEP state.
REQ-014 SHALL have port: steps_left  out  STEP_W  remaining periods in the current burst.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and STEP.
REQ-016 SHALL define half = div_reg, or 1 when div_reg==0.
REQ-017 SHALL, in IDLE, hold cnt=0 and clk_out=0, assert no tick, and hold busy=0.
REQ-018 SHALL, in RUN or STEP, increment cnt every cycle.
REQ-019 SHALL, in RUN or STEP, when cnt >= half-1: set cnt<=0 and toggle clk_out; tick=1 on a low->high toggle only.
REQ-020 SHALL make the first clk_out rise occur exactly half cycles after the edge entering RUN or STEP; full period is 2*half cycles.
REQ-021 SHALL transition IDLE->RUN when run=1; run has priority over a simultaneous step_req.
REQ-022 SHALL transition IDLE->STEP on step_req=1 with run=0 and step_n!=0, loading steps_left<=step_n.
REQ-023 SHALL ignore step_req with step_n==0.
REQ-024 SHALL ignore step_req while in RUN or STEP.
REQ-025 SHALL decrement steps_left on each tick.
REQ-026 SHALL, in STEP, transition STEP->IDLE at the falling toggle of clk_out when steps_left==0; ignore run while in STEP.
REQ-027 SHALL, when run=0 in RUN, transition RUN->IDLE only at the next falling toggle of clk_out, so no truncated high phase occurs.
REQ-028 SHALL transition RUN->IDLE on the next cycle when run=0 while clk_out=0 and cnt==0.
REQ-029 SHALL, on div_load, update div_reg<=div_val at that edge in any state, with cnt unchanged.
REQ-030 SHALL apply a new half-period through the >= compare, so a current cnt beyond the new terminal wraps on the next cycle.
REQ-031 SHALL keep cnt wrap-around impossible, since the terminal compare precedes overflow.
REQ-032 SHALL keep steps_left from going below 0.

Reset
REQ-033 SHALL, while rst=1, immediately force: state=IDLE, cnt=0, clk_out=0, tick=0, busy=0, steps_left=0, div_reg=DIV_DEFAULT.
REQ-034 SHALL, on rst assertion mid-RUN or mid-STEP, abort immediately without completing the period.
REQ-035 SHALL resume normal operation on the first clk edge after rst deasserts.

Verification
REQ-036 SHALL cover: rst, then run=1 with default div -> first clk_out rise 100 cycles after entering RUN, period 200 cycles, tick every 200 cycles, one cycle wide.
REQ-037 SHALL cover: RUN, div_load with div_val=4 -> following half-periods are 4 cycles; no glitch shorter than 1 cycle.
REQ-038 SHALL cover: IDLE, step_req with step_n=3 -> exactly 3 ticks, steps_left 3->2->1->0, busy drops after the third falling edge.
REQ-039 SHALL cover: run dropped while clk_out high -> high phase completes, clk_out falls, state IDLE, no further tick.
REQ-040 SHALL cover: rst pulse mid-STEP between clk edges -> clk_out, busy and steps_left read 0 before the next edge.
REQ-041 SHALL cover: div_val=0 loaded -> clk_out toggles every cycle, tick every 2 cycles.

Source files
------------

// File: rtl/edsac_clk_gen.sv
// EDSAC-style programmable clock generator.
// Divides the system clock by a loadable half-period and produces a
// free-running (RUN) or counted-burst (STEP) output clock plus a rising-edge
// tick pulse. Stopping is always aligned to a falling edge of clk_out so a
// high phase is never cut short.
module edsac_clk_gen #(
  parameter int DIV_W       = 8,
  parameter int DIV_DEFAULT = 100,
  parameter int STEP_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_n,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_val,
  output logic              clk_out,
  output logic              tick,
  output logic              busy,
  output logic [STEP_W-1:0] steps_left
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STEP = 2'd2;

  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0]  DIV_RST  = DIV_W'(DIV_DEFAULT);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              clkOut_q, clkOut_d;
  logic              tick_q, tick_d;
  logic [STEP_W-1:0] stepsLeft_q, stepsLeft_d;

  logic [DIV_W-1:0]  half;
  logic              terminal;
  logic              runStop;

  // A zero divisor is treated as one so the output toggles every cycle.
  always_comb begin
    half     = (div_q == '0) ? DIV_ONE : div_q;
    terminal = (cnt_q >= (half - DIV_ONE));
    runStop  = (state_q == RUN) && !run;
  end

  // Next-state logic: phase counting, edge generation and mode changes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clkOut_d    = clkOut_q;
    tick_d      = 1'b0;
    stepsLeft_d = stepsLeft_q;
    div_d       = div_load ? div_val : div_q;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        clkOut_d = 1'b0;
        if (run) begin
          state_d = RUN;
        end else if (step_req && (step_n != '0)) begin
          state_d     = STEP;
          stepsLeft_d = step_n;
        end
      end

      RUN, STEP: begin
        if (runStop && !clkOut_q && (cnt_q == '0)) begin
          state_d = IDLE;
        end else if (terminal) begin
          cnt_d    = '0;
          clkOut_d = ~clkOut_q;
          if (clkOut_q) begin
            if (runStop || ((state_q == STEP) && (stepsLeft_q == '0))) begin
              state_d = IDLE;
            end
          end else begin
            tick_d = 1'b1;
            if (stepsLeft_q != '0) begin
              stepsLeft_d = stepsLeft_q - STEP_ONE;
            end
          end
        end else begin
          cnt_d = cnt_q + DIV_ONE;
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        clkOut_d = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any period in progress immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_q       <= DIV_RST;
      clkOut_q    <= 1'b0;
      tick_q      <= 1'b0;
      stepsLeft_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      clkOut_q    <= clkOut_d;
      tick_q      <= tick_d;
      stepsLeft_q <= stepsLeft_d;
    end
  end

  assign clk_out    = clkOut_q;
  assign tick       = tick_q;
  assign busy       = (state_q != IDLE);
  assign steps_left = stepsLeft_q;

endmodule

// File: tb/tb_edsac_clk_gen.sv
// Testbench for edsac_clk_gen: directed scenarios followed by a randomized
// run, every cycle compared against a behavioural model of the generator.
module tb_edsac_clk_gen;

  localparam int DIV_W  = 8;
  localparam int STEP_W = 8;

  logic              clock;
  logic              reset;
  logic              runIn;
  logic              stepReq;
  logic [STEP_W-1:0] stepN;
  logic              divLoad;
  logic [DIV_W-1:0]  divVal;
  logic              clkOut;
  logic              tickOut;
  logic              busyOut;
  logic [STEP_W-1:0] stepsLeft;

  int errCount   = 0;
  int checkCount = 0;

  // Behavioural model state.
  typedef enum {M_IDLE, M_RUN, M_STEP} modeT;
  modeT mMode;
  int   mAge;
  int   mDiv;
  int   mLevel;
  int   mTick;
  int   mLeft;

  edsac_clk_gen #(
    .DIV_W(DIV_W),
    .DIV_DEFAULT(100),
    .STEP_W(STEP_W)
  ) dut (
    .clk(clock),
    .rst(reset),
    .run(runIn),
    .step_req(stepReq),
    .step_n(stepN),
    .div_load(divLoad),
    .div_val(divVal),
    .clk_out(clkOut),
    .tick(tickOut),
    .busy(busyOut),
    .steps_left(stepsLeft)
  );

  // Free-running system clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mMode  = M_IDLE;
    mAge   = 0;
    mDiv   = 100;
    mLevel = 0;
    mTick  = 0;
    mLeft  = 0;
  endtask

  // One clock edge of the generator described in terms of phases: each phase
  // of clk_out lasts 'half' cycles; the phase age counts cycles already spent.
  task automatic modelStep(input int r, input int sReq, input int sN,
                           input int dLoad, input int dVal);
    int half;
    bit phaseDone;
    half      = (mDiv == 0) ? 1 : mDiv;
    phaseDone = (mAge + 1 >= half);
    mTick     = 0;
    if (mMode == M_IDLE) begin
      mAge   = 0;
      mLevel = 0;
      if (r != 0) mMode = M_RUN;
      else if (sReq != 0 && sN != 0) begin
        mMode = M_STEP;
        mLeft = sN;
      end
    end else if (mMode == M_RUN && r == 0 && mLevel == 0 && mAge == 0) begin
      mMode = M_IDLE;
    end else if (phaseDone) begin
      mAge = 0;
      if (mLevel == 1) begin
        mLevel = 0;
        if ((mMode == M_RUN && r == 0) || (mMode == M_STEP && mLeft == 0))
          mMode = M_IDLE;
      end else begin
        mLevel = 1;
        mTick  = 1;
        if (mLeft > 0) mLeft = mLeft - 1;
      end
    end else begin
      mAge = mAge + 1;
    end
    if (dLoad != 0) mDiv = dVal;
  endtask

  task automatic compareAll(input string where);
    checkOutput({where, ".clk_out"}, int'(clkOut), mLevel);
    checkOutput({where, ".tick"}, int'(tickOut), mTick);
    checkOutput({where, ".busy"}, int'(busyOut), (mMode != M_IDLE) ? 1 : 0);
    checkOutput({where, ".steps_left"}, int'(stepsLeft), mLeft);
  endtask

  // Drive one cycle of inputs, clock it, advance the model and compare.
  // Pulse inputs are cleared afterwards.
  task automatic applyStimulus(input bit r, input bit sReq, input int sN,
                               input bit dLoad, input int dVal);
    runIn   = r;
    stepReq = sReq;
    stepN   = STEP_W'(sN);
    divLoad = dLoad;
    divVal  = DIV_W'(dVal);
    @(posedge clock);
    #1;
    modelStep(int'(r), int'(sReq), sN, int'(dLoad), dVal);
    compareAll("cycle");
    stepReq = 1'b0;
    divLoad = 1'b0;
  endtask

  // Pulse reset between clock edges and check that outputs clear at once.
  task automatic asyncReset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput({tag, ".clk_out"}, int'(clkOut), 0);
    checkOutput({tag, ".busy"}, int'(busyOut), 0);
    checkOutput({tag, ".steps_left"}, int'(stepsLeft), 0);
    checkOutput({tag, ".tick"}, int'(tickOut), 0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int ticks;
    bit seen;

    reset   = 1'b1;
    runIn   = 1'b0;
    stepReq = 1'b0;
    stepN   = '0;
    divLoad = 1'b0;
    divVal  = '0;
    modelReset();
    #1;
    compareAll("reset");
    #1;
    reset = 1'b0;

    // Free run at the default divisor: first rise 100 cycles after entry.
    applyStimulus(1, 0, 0, 0, 0);
    n = 0;
    seen = 0;
    while (!seen && n < 300) begin
      applyStimulus(1, 0, 0, 0, 0);
      n++;
      if (clkOut) seen = 1;
    end
    checkOutput("firstRiseDelay", n, 100);
    checkOutput("firstRiseTick", int'(tickOut), 1);
    n = 0;
    seen = 0;
    while (!seen && n < 400) begin
      applyStimulus(1, 0, 0, 0, 0);
      n++;
      if (tickOut) seen = 1;
    end
    checkOutput("tickPeriodDefault", n, 200);

    // Shrink the half-period to 4 while running.
    for (int i = 0; i < 37; i++) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 4);
    for (int i = 0; i < 30; i++) applyStimulus(1, 0, 0, 0, 0);
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      applyStimulus(1, 0, 0, 0, 0);
      if (tickOut) seen = 1;
    end
    seen = 0;
    while (!seen && n < 20) begin
      applyStimulus(1, 0, 0, 0, 0);
      n++;
      if (tickOut) seen = 1;
    end
    checkOutput("tickPeriodDiv4", n, 8);

    // Drop run while clk_out is high: high phase completes, then idle.
    n = 0;
    while (!clkOut && n < 20) begin
      applyStimulus(1, 0, 0, 0, 0);
      n++;
    end
    checkOutput("waitHigh", int'(clkOut), 1);
    applyStimulus(0, 0, 0, 0, 0);
    n = 0;
    while (busyOut && n < 20) begin
      applyStimulus(0, 0, 0, 0, 0);
      n++;
    end
    checkOutput("runStopBusy", int'(busyOut), 0);
    checkOutput("runStopLevel", int'(clkOut), 0);
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      ticks += int'(tickOut);
    end
    checkOutput("ticksAfterStop", ticks, 0);

    // A zero-length burst request is ignored.
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("stepZeroIgnored", int'(busyOut), 0);

    // Burst of three periods.
    applyStimulus(0, 1, 3, 0, 0);
    checkOutput("stepLoad", int'(stepsLeft), 3);
    ticks = 0;
    n = 0;
    while (busyOut && n < 60) begin
      applyStimulus(0, 0, 0, 0, 0);
      n++;
      if (tickOut) begin
        ticks++;
        checkOutput("stepCountdown", int'(stepsLeft), 3 - ticks);
      end
    end
    checkOutput("stepTicks", ticks, 3);
    checkOutput("stepEndLevel", int'(clkOut), 0);
    checkOutput("stepCycles", n, 24);

    // Reset in the middle of a burst.
    applyStimulus(0, 1, 5, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, 0);
    asyncReset("midStepReset");
    applyStimulus(0, 0, 0, 0, 0);

    // Divisor of zero: toggle every cycle, tick every two cycles.
    applyStimulus(1, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 0);
    n = 0;
    seen = 0;
    while (!seen && n < 10) begin
      applyStimulus(1, 0, 0, 0, 0);
      if (tickOut) seen = 1;
      n++;
    end
    n = 0;
    seen = 0;
    while (!seen && n < 10) begin
      applyStimulus(1, 0, 0, 0, 0);
      n++;
      if (tickOut) seen = 1;
    end
    checkOutput("tickPeriodDiv0", n, 2);
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);

    // Randomized traffic with small divisors.
    applyStimulus(0, 0, 0, 1, 3);
    begin
      bit r;
      r = 0;
      for (int i = 0; i < 4000; i++) begin
        bit sReq;
        bit dLoad;
        if ($urandom_range(0, 39) == 0) r = ~r;
        sReq  = ($urandom_range(0, 14) == 0);
        dLoad = ($urandom_range(0, 59) == 0);
        applyStimulus(r, sReq, int'($urandom_range(0, 4)), dLoad,
                      int'($urandom_range(0, 6)));
        if ($urandom_range(0, 499) == 0) begin
          asyncReset("randReset");
          applyStimulus(0, 0, 0, 1, 2);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
